seq_det_prog: RTL
=================

// Module: seq_det_prog
// PURPOSE
//  Parametrised, run-time programmable serial bit-pattern detector (Moore-style registered output).
//  Generalises the fixed 4-bit "1000" detector: pattern length up to PAT_W, pattern loadable, overlap mode selectable, input qualified by valid.
//  Sits on a serial data path and emits a one-cycle match pulse per detected occurrence.
// PARAMETERS
//  PAT_W       8         max pattern length in bits (>=2)
//  DEF_PATTERN 8'h08     pattern after reset (LSB-aligned; bit DEF_LEN-1 = first bit received)
//  DEF_LEN     4         pattern length after reset (1..PAT_W); default = "1000"
//  CNT_W       8         width of match counter (optional feature)
// PORTS
//  clk          in   1                  clock, rising edge
//  rst          in   1                  synchronous reset, active-high
//  din          in   1                  serial data bit
//  din_valid    in   1                  din accepted on this edge when 1
//  ovl_en       in   1                  1 = overlapping detection, 0 = non-overlapping; sampled each cycle
//  cfg_load     in   1                  load new pattern/length this edge
//  cfg_pattern  in   PAT_W              new pattern, LSB-aligned, bit cfg_len-1 received first
//  cfg_len      in   $clog2(PAT_W+1)    new length
//  match        out  1                  one-cycle pulse: pattern completed on previous edge
//  cfg_err      out  1                  one-cycle pulse: cfg_load rejected
//  match_count  out  CNT_W              saturating count of matches (feature-gated)
// BEHAVIOUR
//  - One clock, clk; rst synchronous active-high, highest priority over all inputs.
//  - Reset: pat=DEF_PATTERN, len=DEF_LEN, hist=0, fill=0, match=0, cfg_err=0, match_count=0.
//  - State: hist[PAT_W-1:0] (last accepted bits, newest in bit 0), fill (bits accepted since clear, saturates at PAT_W).
//  - Accept (din_valid=1, no cfg_load): hist <= {hist[PAT_W-2:0],din}; fill <= min(fill+1,PAT_W).
//  - Match condition on the updated values: fill' >= len AND hist'[len-1:0] == pat[len-1:0].
//  - match <= that condition; asserted exactly in the cycle after the edge sampling the final bit; else 0.
//  - No accept on an edge -> match <= 0 (pulse only, never held); hist/fill unchanged.
//  - On match: ovl_en=1 -> fill kept (suffix bits may start the next match);
//    ovl_en=0 -> fill <= 0 (matched bits consumed; next match needs len fresh bits).
//  - cfg_load, legal (1<=cfg_len<=PAT_W): pat<=cfg_pattern, len<=cfg_len, hist<=0, fill<=0, match<=0.
//    din_valid in the same cycle is ignored (cfg_load wins).
//  - cfg_load, illegal (cfg_len==0 or >PAT_W): cfg_err<=1 for one cycle; pat/len/hist/fill unchanged; din_valid
//    in that cycle is processed normally.
//  - cfg_pattern bits above cfg_len-1 are don't-care; they do not affect comparison.
//  - rst asserted mid-stream: all state returns to reset values on that edge; partial match discarded.
// CONFIGURATION
//  - Macro SEQ_DET_MATCH_CNT_EN:
//    defined  -> match_count increments on every edge where match is set to 1, saturates at 2^CNT_W-1,
//                cleared by rst and by legal cfg_load.
//    undefined -> no counter logic; match_count tied to 0. Port list identical in both builds.
// STRUCTURE
//  - Package seq_det_pkg: PAT_W/CNT_W default constants, LEN_W = $clog2(PAT_W+1) localparam function,
//    pattern-mask helper (len -> bit mask).
//  - Sub-module seq_det_hist: hist shift register + saturating fill counter with accept/clear inputs.
//  - Top seq_det_prog: config registers, legality check, masked compare, output/counter registers.
// TESTING
//  1. Defaults, stream 1,0,0,0 (valid each cycle) -> match=1 only the cycle after 4th bit; match_count=1.
//  2. Load 3'b101 len 3, ovl_en=1, stream 1,0,1,0,1 -> match after bits 3 and 5 (count 2);
//     repeat with ovl_en=0 -> match after bit 3 only.
//  3. Defaults, stream 1,gap,0,gap,gap,0,0 (din_valid low in gaps) -> single match after final 0; match=0 in gaps.
//  4. After 1,0,0 load pattern 2'b11 len 2 -> hist cleared; feed 0 -> no match; feed 1,1 -> match.
//  5. PAT_W=8: cfg_load with cfg_len=0, then 9 -> cfg_err pulses each time; "1000" still detected.
//  6. rst=1 with din_valid=1 on the edge completing a match -> match=0, fill=0, match_count=0.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the programmable serial pattern detector.
// Mask helper covers patterns up to MASK_W bits wide.
package seq_det_pkg;

  localparam int PAT_W_DEF = 8;
  localparam int CNT_W_DEF = 8;
  localparam int MASK_W    = 32;

  function automatic int len_w(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction

  // Ones in bit positions 0..len-1; all higher positions are don't-care.
  function automatic logic [MASK_W-1:0] len_mask(input int len);
    logic [MASK_W-1:0] m;
    m = '0;
    for (int i = 0; i < MASK_W; i++) begin
      if (i < len) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/seq_det_hist.sv
// Serial history shift register with a saturating fill counter.
// Presents the post-accept history/fill so the caller can judge a match on the same edge.
module seq_det_hist
  import seq_det_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF,
  parameter int LEN_W = len_w(PAT_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             accept,
  input  logic             clear,
  input  logic             consume,
  input  logic             din,
  output logic [PAT_W-1:0] hist_acc,
  output logic [LEN_W-1:0] fill_acc
);

  // Only PAT_W-1 bits need storing: the oldest bit falls out on the next accept.
  logic [PAT_W-2:0] hist;
  logic [LEN_W-1:0] fill;

  always_comb begin
    hist_acc = {hist, din};
    fill_acc = (fill == LEN_W'(PAT_W)) ? fill : fill + LEN_W'(1);
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst || clear) begin
      hist <= '0;
      fill <= '0;
    end else if (accept) begin
      hist <= hist_acc[PAT_W-2:0];
      fill <= consume ? '0 : fill_acc;
    end
  end

endmodule

// File: rtl/seq_det_prog.sv
// Run-time programmable serial bit-pattern detector with registered one-cycle match pulse.
// Optional saturating match counter enabled by defining SEQ_DET_MATCH_CNT_EN.
module seq_det_prog
  import seq_det_pkg::*;
#(
  parameter int               PAT_W       = PAT_W_DEF,
  parameter logic [PAT_W-1:0] DEF_PATTERN = PAT_W'('h08),
  parameter int               DEF_LEN     = 4,
  parameter int               CNT_W       = CNT_W_DEF,
  localparam int              LEN_W       = len_w(PAT_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_valid,
  input  logic             ovl_en,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  output logic             match,
  output logic             cfg_err,
  output logic [CNT_W-1:0] match_count
);

  logic [PAT_W-1:0] pat;
  logic [LEN_W-1:0] len;
  logic [PAT_W-1:0] hist_acc;
  logic [LEN_W-1:0] fill_acc;
  logic             len_legal, load_ok, load_bad, accept, hit, consume;

  always_comb begin
    // NOTE: every output assigned up front so no path infers a latch.
    len_legal = (cfg_len != '0) && (cfg_len <= LEN_W'(PAT_W));
    load_ok   = cfg_load && len_legal;
    load_bad  = cfg_load && !len_legal;
    accept    = din_valid && !load_ok;
    hit       = accept && (fill_acc >= len) &&
                (((MASK_W'(hist_acc) ^ MASK_W'(pat)) & len_mask(int'(len))) == '0);
    consume   = hit && !ovl_en;
  end

  seq_det_hist #(
    .PAT_W (PAT_W),
    .LEN_W (LEN_W)
  ) u_hist (
    .clk      (clk),
    .rst      (rst),
    .accept   (accept),
    .clear    (load_ok),
    .consume  (consume),
    .din      (din),
    .hist_acc (hist_acc),
    .fill_acc (fill_acc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pat     <= DEF_PATTERN;
      len     <= LEN_W'(DEF_LEN);
      match   <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      match   <= hit;
      cfg_err <= load_bad;
      if (load_ok) begin
        pat <= cfg_pattern;
        len <= cfg_len;
      end
    end
  end

`ifdef SEQ_DET_MATCH_CNT_EN
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || load_ok) begin
      cnt <= '0;
    end else if (hit && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign match_count = cnt;
`else
  assign match_count = '0;
`endif

endmodule
